// File: rtl/code_verifier.sv
// ---------------------------------------------------------------------------
// code_verifier
//
// Holds a one-time 4-digit BCD code captured from the random generator,
// collects keypad digits, compares them on enter and reports unlock, error
// and lockout status. Consecutive mismatches up to MAX_FAIL force a timed
// lockout; a successful match opens the safe for a fixed time and burns
// the code.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   gen_req           pulse: capture {d1,d2,d3,d4} as the new code
//   d1..d4            code digits, d1 = thousands
//   key_valid         pulse: key_digit carries a keypad digit
//   key_digit         keypad digit (values above 9 are ignored)
//   key_clear         pulse: discard the current entry
//   key_enter         pulse: submit the current entry
//   unlock            high while the safe is open
//   locked            high during lockout
//   err_pulse         one-cycle pulse per mismatch
//   armed             a code is held and entry is allowed
//   entry_cnt         number of digits entered (0..4)
//   entry_digits      entered digits, first digit in [15:12], unused nibbles 0
//   fail_cnt          consecutive mismatch count
//   state_dbg         current state encoding
// ---------------------------------------------------------------------------
module code_verifier #(
    parameter int unsigned MAX_FAIL    = 3,
    parameter int unsigned OPEN_CYCLES = 50_000_000,
    parameter int unsigned LOCK_CYCLES = 250_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gen_req,
    input  logic [3:0]  d1,
    input  logic [3:0]  d2,
    input  logic [3:0]  d3,
    input  logic [3:0]  d4,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    input  logic        key_clear,
    input  logic        key_enter,
    output logic        unlock,
    output logic        locked,
    output logic        err_pulse,
    output logic        armed,
    output logic [2:0]  entry_cnt,
    output logic [15:0] entry_digits,
    output logic [3:0]  fail_cnt,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_ENTRY   = 3'd2,
        ST_CHECK   = 3'd3,
        ST_OPEN    = 3'd4,
        ST_LOCKOUT = 3'd5
    } state_e;

    // The dwell counter counts down to zero inclusive, so load N-1 for N cycles.
    localparam logic [31:0] OPEN_LOAD  = 32'(OPEN_CYCLES - 1);
    localparam logic [31:0] LOCK_LOAD  = 32'(LOCK_CYCLES - 1);
    localparam logic [3:0]  MAX_FAIL_V = 4'(MAX_FAIL);

    // A keypad value is a usable digit only in the BCD range.
    function automatic logic digit_ok(input logic [3:0] dig);
        return (dig <= 4'd9);
    endfunction

    // Write a digit into the nibble selected by the current entry count,
    // filling from the most significant nibble downward.
    function automatic logic [15:0] place_digit(input logic [15:0] entry,
                                                input logic [2:0]  pos,
                                                input logic [3:0]  dig);
        logic [15:0] res;
        res = entry;
        case (pos)
            3'd0:    res[15:12] = dig;
            3'd1:    res[11:8]  = dig;
            3'd2:    res[7:4]   = dig;
            3'd3:    res[3:0]   = dig;
            default: res        = entry;
        endcase
        return res;
    endfunction

    state_e      state_q,  state_d;
    logic [15:0] code_q,   code_d;
    logic [15:0] entry_q,  entry_d;
    logic [2:0]  cnt_q,    cnt_d;
    logic [3:0]  fail_q,   fail_d;
    logic [31:0] dwell_q,  dwell_d;
    logic        unlock_q, unlock_d;
    logic        locked_q, locked_d;
    logic        err_q,    err_d;
    logic        armed_q,  armed_d;

    logic        clr_ev_s;
    logic        ent_ev_s;
    logic        dig_ev_s;
    logic [3:0]  fail_inc_s;
    logic        match_s;

    // Resolve same-cycle keypad events: clear beats enter beats digit.
    always_comb begin
        clr_ev_s   = key_clear;
        ent_ev_s   = key_enter & ~key_clear;
        dig_ev_s   = key_valid & ~key_clear & ~key_enter & digit_ok(key_digit);
        fail_inc_s = fail_q + 4'd1;
        match_s    = (cnt_q == 3'd4) && (entry_q == code_q);
    end

    // Next-state and next-output computation for the verifier FSM.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        entry_d = entry_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        dwell_d = dwell_q;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (gen_req) begin
                    code_d  = {d1, d2, d3, d4};
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ARMED: begin
                if (gen_req) begin
                    code_d = {d1, d2, d3, d4};
                end else begin
                    code_d = code_q;
                end
                if (clr_ev_s) begin
                    entry_d = 16'd0;
                    cnt_d   = 3'd0;
                end else if (ent_ev_s) begin
                    // Submitting an empty entry is judged (and fails) in CHECK.
                    state_d = ST_CHECK;
                end else if (dig_ev_s) begin
                    entry_d = {key_digit, 12'd0};
                    cnt_d   = 3'd1;
                    state_d = ST_ENTRY;
                end else begin
                    state_d = ST_ARMED;
                end
            end

            ST_ENTRY: begin
                if (clr_ev_s) begin
                    entry_d = 16'd0;
                    cnt_d   = 3'd0;
                    state_d = ST_ARMED;
                end else if (ent_ev_s) begin
                    state_d = ST_CHECK;
                end else if (dig_ev_s && (cnt_q < 3'd4)) begin
                    entry_d = place_digit(entry_q, cnt_q, key_digit);
                    cnt_d   = cnt_q + 3'd1;
                end else begin
                    state_d = ST_ENTRY;
                end
            end

            ST_CHECK: begin
                entry_d = 16'd0;
                cnt_d   = 3'd0;
                if (match_s) begin
                    fail_d  = 4'd0;
                    code_d  = 16'd0;
                    dwell_d = OPEN_LOAD;
                    state_d = ST_OPEN;
                end else begin
                    err_d  = 1'b1;
                    fail_d = fail_inc_s;
                    if (fail_inc_s == MAX_FAIL_V) begin
                        dwell_d = LOCK_LOAD;
                        state_d = ST_LOCKOUT;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
            end

            ST_OPEN: begin
                if (dwell_q == 32'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    dwell_d = dwell_q - 32'd1;
                end
            end

            ST_LOCKOUT: begin
                if (dwell_q == 32'd0) begin
                    fail_d  = 4'd0;
                    code_d  = 16'd0;
                    state_d = ST_IDLE;
                end else begin
                    dwell_d = dwell_q - 32'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                code_d  = 16'd0;
                entry_d = 16'd0;
                cnt_d   = 3'd0;
                fail_d  = 4'd0;
                dwell_d = 32'd0;
            end
        endcase

        // Status flags follow the state being entered so they are registered.
        unlock_d = (state_d == ST_OPEN);
        locked_d = (state_d == ST_LOCKOUT);
        armed_d  = (state_d == ST_ARMED) || (state_d == ST_ENTRY);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            code_q   <= 16'd0;
            entry_q  <= 16'd0;
            cnt_q    <= 3'd0;
            fail_q   <= 4'd0;
            dwell_q  <= 32'd0;
            unlock_q <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            entry_q  <= entry_d;
            cnt_q    <= cnt_d;
            fail_q   <= fail_d;
            dwell_q  <= dwell_d;
            unlock_q <= unlock_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            armed_q  <= armed_d;
        end
    end

    assign unlock       = unlock_q;
    assign locked       = locked_q;
    assign err_pulse    = err_q;
    assign armed        = armed_q;
    assign entry_cnt    = cnt_q;
    assign entry_digits = entry_q;
    assign fail_cnt     = fail_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_code_verifier.sv
// ---------------------------------------------------------------------------
// tb_code_verifier
//
// Directed scenarios followed by randomized keypad traffic. A behavioural
// model (digit queue, integer counters, elapsed-time tracking) predicts every
// output after each clock edge.
// ---------------------------------------------------------------------------
module tb_code_verifier;

    localparam int MAXF  = 3;
    localparam int OPENC = 8;
    localparam int LOCKC = 16;

    // Phase numbers are the externally visible state_dbg values.
    localparam int P_IDLE = 0, P_ARMED = 1, P_ENTRY = 2, P_CHECK = 3, P_OPEN = 4, P_LOCK = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        gen_req;
    logic [3:0]  d1, d2, d3, d4;
    logic        key_valid;
    logic [3:0]  key_digit;
    logic        key_clear;
    logic        key_enter;
    logic        unlock, locked, err_pulse, armed;
    logic [2:0]  entry_cnt;
    logic [15:0] entry_digits;
    logic [3:0]  fail_cnt;
    logic [2:0]  state_dbg;

    int total = 0;
    int bad   = 0;

    // Model state
    int m_phase;
    int m_code[4];
    int m_keys[$];
    int m_fails;
    int m_elapsed;
    int m_err;

    // Observation counters for duration checks
    int n_unlock, n_locked, n_err;

    code_verifier #(.MAX_FAIL(MAXF), .OPEN_CYCLES(OPENC), .LOCK_CYCLES(LOCKC)) dut (
        .clk(clk), .rst_n(rst_n), .gen_req(gen_req),
        .d1(d1), .d2(d2), .d3(d3), .d4(d4),
        .key_valid(key_valid), .key_digit(key_digit),
        .key_clear(key_clear), .key_enter(key_enter),
        .unlock(unlock), .locked(locked), .err_pulse(err_pulse), .armed(armed),
        .entry_cnt(entry_cnt), .entry_digits(entry_digits),
        .fail_cnt(fail_cnt), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_digits();
        logic [15:0] v;
        v = 16'd0;
        for (int i = 0; i < m_keys.size(); i++) begin
            v = v | (16'(m_keys[i]) << (12 - 4 * i));
        end
        return v;
    endfunction

    task automatic model_reset();
        m_phase   = P_IDLE;
        for (int i = 0; i < 4; i++) m_code[i] = 0;
        m_keys    = {};
        m_fails   = 0;
        m_elapsed = 0;
        m_err     = 0;
    endtask

    // One clock of the reference behaviour, written from the rules directly.
    task automatic model_step(input logic g, input logic [15:0] dd, input logic kv,
                              input logic [3:0] kd, input logic kc, input logic ke);
        bit match;
        m_err = 0;
        case (m_phase)
            P_IDLE: begin
                if (g) begin
                    for (int i = 0; i < 4; i++) m_code[i] = int'(dd[15 - 4 * i -: 4]);
                    m_phase = P_ARMED;
                end
            end
            P_ARMED: begin
                if (g) for (int i = 0; i < 4; i++) m_code[i] = int'(dd[15 - 4 * i -: 4]);
                if (kc) begin
                    m_keys = {};
                end else if (ke) begin
                    m_phase = P_CHECK;
                end else if (kv && kd <= 4'd9) begin
                    m_keys.push_back(int'(kd));
                    m_phase = P_ENTRY;
                end
            end
            P_ENTRY: begin
                if (kc) begin
                    m_keys  = {};
                    m_phase = P_ARMED;
                end else if (ke) begin
                    m_phase = P_CHECK;
                end else if (kv && kd <= 4'd9 && m_keys.size() < 4) begin
                    m_keys.push_back(int'(kd));
                end
            end
            P_CHECK: begin
                match = (m_keys.size() == 4);
                if (match) for (int i = 0; i < 4; i++) if (m_keys[i] != m_code[i]) match = 0;
                m_keys = {};
                m_elapsed = 0;
                if (match) begin
                    m_phase = P_OPEN;
                    m_fails = 0;
                    for (int i = 0; i < 4; i++) m_code[i] = 0;
                end else begin
                    m_err   = 1;
                    m_fails = m_fails + 1;
                    m_phase = (m_fails == MAXF) ? P_LOCK : P_ARMED;
                end
            end
            P_OPEN: begin
                m_elapsed++;
                if (m_elapsed == OPENC) m_phase = P_IDLE;
            end
            P_LOCK: begin
                m_elapsed++;
                if (m_elapsed == LOCKC) begin
                    m_phase = P_IDLE;
                    m_fails = 0;
                    for (int i = 0; i < 4; i++) m_code[i] = 0;
                end
            end
            default: m_phase = P_IDLE;
        endcase
    endtask

    task automatic compare_all();
        check_eq("state",   32'(state_dbg),    32'(m_phase));
        check_eq("unlock",  32'(unlock),       32'(m_phase == P_OPEN));
        check_eq("locked",  32'(locked),       32'(m_phase == P_LOCK));
        check_eq("armed",   32'(armed),        32'(m_phase == P_ARMED || m_phase == P_ENTRY));
        check_eq("err",     32'(err_pulse),    32'(m_err));
        check_eq("ecnt",    32'(entry_cnt),    32'(m_keys.size()));
        check_eq("edigits", 32'(entry_digits), 32'(model_digits()));
        check_eq("fails",   32'(fail_cnt),     32'(m_fails));
    endtask

    // Drive one cycle of inputs at the falling edge, step the model at the
    // rising edge, compare at the next falling edge.
    task automatic tick(input logic g, input logic [15:0] dd, input logic kv,
                        input logic [3:0] kd, input logic kc, input logic ke);
        gen_req   = g;
        {d1, d2, d3, d4} = dd;
        key_valid = kv;
        key_digit = kd;
        key_clear = kc;
        key_enter = ke;
        @(posedge clk);
        model_step(g, dd, kv, kd, kc, ke);
        @(negedge clk);
        compare_all();
        n_unlock += int'(unlock);
        n_locked += int'(locked);
        n_err    += int'(err_pulse);
        gen_req   = 1'b0;
        key_valid = 1'b0;
        key_clear = 1'b0;
        key_enter = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 16'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic gen(input logic [15:0] dd);
        tick(1'b1, dd, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic key(input logic [3:0] kd);
        tick(1'b0, 16'd0, 1'b1, kd, 1'b0, 1'b0);
    endtask

    task automatic enter();
        tick(1'b0, 16'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    endtask

    task automatic clr();
        tick(1'b0, 16'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    endtask

    task automatic clear_counts();
        n_unlock = 0;
        n_locked = 0;
        n_err    = 0;
    endtask

    initial begin
        logic        g, kv, kc, ke;
        logic [15:0] dd;
        logic [3:0]  kd;

        rst_n = 1'b0;
        gen_req = 1'b0; key_valid = 1'b0; key_clear = 1'b0; key_enter = 1'b0;
        key_digit = 4'd0; {d1, d2, d3, d4} = 16'd0;
        model_reset();
        clear_counts();
        repeat (2) @(negedge clk);

        // Reset state
        check_eq("rst_state",  32'(state_dbg),    32'd0);
        check_eq("rst_unlock", 32'(unlock),       32'd0);
        check_eq("rst_locked", 32'(locked),       32'd0);
        check_eq("rst_armed",  32'(armed),        32'd0);
        check_eq("rst_digits", 32'(entry_digits), 32'd0);
        check_eq("rst_fails",  32'(fail_cnt),     32'd0);
        rst_n = 1'b1;

        // Keys in IDLE are ignored
        key(4'd5);
        check_eq("idle_ignore", 32'(entry_cnt), 32'd0);

        // Plain unlock, open for exactly OPENC cycles
        gen(16'h1234);
        key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        enter();
        clear_counts();
        idle(1);
        check_eq("t1_unlock_n2", 32'(unlock), 32'd1);
        idle(11);
        check_eq("t1_open_len", 32'(n_unlock), 32'(OPENC));
        check_eq("t1_idle",     32'(state_dbg), 32'd0);
        check_eq("t1_armed",    32'(armed),     32'd0);

        // Three mismatches, lockout for LOCKC cycles with keys ignored
        gen(16'h9057);
        clear_counts();
        for (int a = 1; a <= MAXF; a++) begin
            key(4'd9); key(4'd0); key(4'd5); key(4'd6);
            enter();
            idle(1);
            check_eq("t2_fail_step", 32'(fail_cnt), 32'(a));
        end
        check_eq("t2_locked", 32'(locked), 32'd1);
        for (int i = 0; i < 20; i++) tick(1'b0, 16'd0, 1'b1, 4'(i % 10), 1'b0, 1'(i % 3 == 0));
        check_eq("t2_err_cnt",  32'(n_err),    32'(MAXF));
        check_eq("t2_lock_len", 32'(n_locked), 32'(LOCKC));
        check_eq("t2_idle",     32'(state_dbg), 32'd0);
        check_eq("t2_fails0",   32'(fail_cnt),  32'd0);

        // Clear discards a partial entry without counting a failure
        gen(16'h4410);
        key(4'd4); key(4'd4);
        clr();
        check_eq("t3_cnt0",  32'(entry_cnt), 32'd0);
        check_eq("t3_fail0", 32'(fail_cnt),  32'd0);
        key(4'd4); key(4'd4); key(4'd1); key(4'd0);
        enter();
        idle(1);
        check_eq("t3_unlock", 32'(unlock), 32'd1);
        idle(10);

        // Fifth digit and invalid digit ignored; short entry fails
        gen(16'h3333);
        key(4'd3); key(4'd3); key(4'd3); key(4'd3); key(4'd7); key(4'd12);
        check_eq("t4_digits", 32'(entry_digits), 32'h3333);
        check_eq("t4_cnt",    32'(entry_cnt),    32'd4);
        enter();
        idle(1);
        check_eq("t4_unlock", 32'(unlock), 32'd1);
        idle(10);
        gen(16'h3333);
        key(4'd3); key(4'd3);
        enter();
        idle(1);
        check_eq("t4_short_err", 32'(err_pulse), 32'd1);
        check_eq("t4_fail1",     32'(fail_cnt),  32'd1);

        // Clear, enter and digit together: only clear acts
        key(4'd3);
        tick(1'b0, 16'd0, 1'b1, 4'd5, 1'b1, 1'b1);
        check_eq("t5_state", 32'(state_dbg), 32'd1);
        check_eq("t5_cnt",   32'(entry_cnt), 32'd0);
        idle(1);
        check_eq("t5_noerr", 32'(err_pulse), 32'd0);
        check_eq("t5_fail",  32'(fail_cnt),  32'd1);

        // Code 0000 matches; reset in OPEN drops unlock immediately
        gen(16'h0000);
        key(4'd0); key(4'd0); key(4'd0); key(4'd0);
        enter();
        idle(3);
        check_eq("t6_open", 32'(unlock), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_rst_unlock", 32'(unlock),    32'd0);
        check_eq("t6_rst_state",  32'(state_dbg), 32'd0);
        check_eq("t6_rst_fails",  32'(fail_cnt),  32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Randomized traffic, digits biased toward the held code
        for (int c = 0; c < 4000; c++) begin
            g  = 1'($urandom_range(0, 99) < 4);
            dd = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                  4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            kv = 1'($urandom_range(0, 99) < 45);
            if (m_keys.size() < 4 && $urandom_range(0, 99) < 75)
                kd = 4'(m_code[m_keys.size()]);
            else
                kd = 4'($urandom_range(0, 15));
            kc = 1'($urandom_range(0, 99) < 3);
            ke = (m_keys.size() == 4) ? 1'($urandom_range(0, 99) < 40)
                                      : 1'($urandom_range(0, 99) < 5);
            tick(g, dd, kv, kd, kc, ke);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
